tdc_delay_line: RTL and testbench

TDC_DELAY_LINE -- requirements
Module: tdc_delay_line

---
 rtl/tdc_pkg.sv | 39 +++
 rtl/tdc_carry_chain.sv | 33 +++
 rtl/tdc_delay_line.sv | 122 ++++++++++++
 tb/tb_tdc_delay_line.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the carry-chain TDC: FSM states, tap/width helpers,
// output latency and a behavioural CARRY4 carry-out function.
`default_nettype none

package tdc_pkg;

  localparam int LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONVERT  = 2'd1,
    WAIT_LOW = 2'd2
  } tdc_state_e;

  function automatic int ntap(input int ncarry4);
    return 4 * ncarry4;
  endfunction

  function automatic int fine_width(input int ncarry4);
    return $clog2(4 * ncarry4 + 1);
  endfunction

  // Each CO bit propagates the running carry when S is set, else loads DI.
  function automatic logic [3:0] carry4_co(input logic ci, input logic [3:0] di,
                                           input logic [3:0] s);
    logic       c;
    logic [3:0] co;
    c  = ci;
    co = '0;
    for (int j = 0; j < 4; j++) begin
      c     = s[j] ? c : di[j];
      co[j] = c;
    end
    return co;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdc_carry_chain.sv
// Cascaded CARRY4 delay line; the hit enters stage 0 on CYINIT and every CO bit
// is exposed as a tap (tap 0 = stage 0 CO[0]).
`default_nettype none

module tdc_carry_chain
  import tdc_pkg::*;
#(
  parameter int NCARRY4 = 4
) (
  input  logic                   hit_i,
  output logic [4*NCARRY4-1:0]   taps_o
);

  logic [4*NCARRY4-1:0] co_all;

  for (genvar i = 0; i < NCARRY4; i++) begin : g_stage
    logic       ci;
    logic [3:0] co;
    if (i == 0) begin : g_first
      // CI is tied low, so the carry-in of the first stage is CYINIT alone
      assign ci = hit_i;
    end else begin : g_cascade
      assign ci = g_stage[i-1].co[3];
    end
    assign co               = carry4_co(ci, 4'h0, 4'hF);
    assign co_all[4*i +: 4] = co;
  end

  assign taps_o = co_all;

endmodule

`default_nettype wire

// File: rtl/tdc_delay_line.sv
// Carry-chain TDC: two-flop tap capture, coarse counter, popcount fine code.
// Optional macro TDC_BUBBLE_FILTER_EN enables 3-tap majority bubble filtering.
`default_nettype none

module tdc_delay_line
  import tdc_pkg::*;
#(
  parameter  int NCARRY4  = 4,
  parameter  int COARSE_W = 8,
  localparam int NTAP     = ntap(NCARRY4),
  localparam int FINE_W   = fine_width(NCARRY4)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                hit_i,
  output logic                valid_o,
  output logic [FINE_W-1:0]   fine_o,
  output logic [COARSE_W-1:0] coarse_o,
  output logic                sat_o,
  output logic                busy_o
);

  logic [NTAP-1:0]     taps;
  logic [NTAP-1:0]     tap_q;
  logic [NTAP-1:0]     tap_qq;
  logic                tap0_d;
  logic [NTAP-1:0]     filt;
  logic [FINE_W-1:0]   pop;
  logic [FINE_W-1:0]   fine_r;
  logic [COARSE_W-1:0] coarse_cnt;
  logic [COARSE_W-1:0] coarse_q;
  logic [COARSE_W-1:0] coarse_qq;
  logic [COARSE_W-1:0] coarse_r;
  tdc_state_e          state;

  tdc_carry_chain #(
    .NCARRY4 (NCARRY4)
  ) u_chain (
    .hit_i  (hit_i),
    .taps_o (taps)
  );

`ifdef TDC_BUBBLE_FILTER_EN
  // Pad below with 1 and above with 0 so the end taps see a sane neighbour.
  logic [NTAP+1:0] ext;
`endif

  always_comb begin
    filt = tap_qq;
`ifdef TDC_BUBBLE_FILTER_EN
    ext = {1'b0, tap_qq, 1'b1};
    for (int i = 0; i < NTAP; i++) begin
      filt[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
`endif
    pop = '0;
    for (int i = 0; i < NTAP; i++) begin
      pop = pop + FINE_W'(filt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_q      <= '0;
      tap_qq     <= '0;
      tap0_d     <= 1'b0;
      coarse_cnt <= '0;
      coarse_q   <= '0;
      coarse_qq  <= '0;
      coarse_r   <= '0;
      fine_r     <= '0;
      state      <= IDLE;
      valid_o    <= 1'b0;
      fine_o     <= '0;
      coarse_o   <= '0;
      sat_o      <= 1'b0;
    end else begin
      tap_q     <= taps;
      tap_qq    <= tap_q;
      tap0_d    <= tap_qq[0];
      coarse_q  <= coarse_cnt;
      coarse_qq <= coarse_q;
      if (en_i) begin
        coarse_cnt <= coarse_cnt + COARSE_W'(1);
      end
      valid_o <= 1'b0;
      if (!en_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // tap_qq now holds the capture-edge sample; coarse_qq is aligned with it
            if (tap_qq[0] && !tap0_d) begin
              state    <= CONVERT;
              fine_r   <= pop;
              coarse_r <= coarse_qq;
            end
          end
          CONVERT: begin
            state    <= WAIT_LOW;
            valid_o  <= 1'b1;
            fine_o   <= fine_r;
            coarse_o <= coarse_r;
            sat_o    <= (fine_r == FINE_W'(NTAP));
          end
          WAIT_LOW: begin
            if (!tap_qq[0]) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tdc_delay_line.sv
// Self-checking bench for tdc_delay_line: taps are forced on the carry chain
// output and every cycle is compared against a behavioural model.
`default_nettype none

module tb_tdc_delay_line;
  import tdc_pkg::*;

  localparam int NTAP = 16;
`ifdef TDC_BUBBLE_FILTER_EN
  localparam int BUBBLE_EXP = 8;
`else
  localparam int BUBBLE_EXP = 7;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        hit = 1'b0;
  logic        valid;
  logic [4:0]  fine;
  logic [7:0]  coarse;
  logic        sat;
  logic        busy;
  logic [15:0] taps_drv = 16'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  always #5 clk = ~clk;

  tdc_delay_line #(
    .NCARRY4  (4),
    .COARSE_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en),
    .hit_i    (hit),
    .valid_o  (valid),
    .fine_o   (fine),
    .coarse_o (coarse),
    .sat_o    (sat),
    .busy_o   (busy)
  );

  task automatic set_taps(input logic [15:0] v);
    taps_drv = v;
    force dut.u_chain.taps_o = taps_drv;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference fine code: count of taps that are set (after majority voting when filtered).
  function automatic int ref_fine(input logic [15:0] t);
    int n = 0;
    for (int i = 0; i < 16; i++) begin
`ifdef TDC_BUBBLE_FILTER_EN
      int votes;
      votes = int'(t[i]);
      if (i == 0) votes += 1;
      else        votes += int'(t[i-1]);
      if (i != 15) votes += int'(t[i+1]);
      if (votes >= 2) n++;
`else
      n += int'(t[i]);
`endif
    end
    return n;
  endfunction

  // Model state: sample history seen by the two capture flops, coarse history,
  // whether a result is in flight, and whether the line must drain low first.
  logic [15:0] h1 = '0, h2 = '0, h3 = '0;
  logic [7:0]  mcnt = '0, c1 = '0, c2 = '0;
  bit          pending = 0, draining = 0, model_ok = 0, cap = 0;
  int          edge_no = 0, due = 0, pfine = 0;
  logic [7:0]  pcoarse = '0;
  bit          e_valid = 0, e_sat = 0, e_busy = 0;
  int          e_fine = 0;
  logic [7:0]  e_coarse = '0;

  always @(posedge clk) begin
    edge_no++;
    if (!rst_n) begin
      h1 = '0; h2 = '0; h3 = '0;
      c1 = '0; c2 = '0; mcnt = '0;
      pending = 0; draining = 0;
      e_valid = 0; e_fine = 0; e_coarse = '0; e_sat = 0;
      model_ok = 1;
    end else begin
      // h2/h3 describe the edge two cycles ago: did tap 0 first rise there?
      cap     = h2[0] && !h3[0];
      e_valid = 0;
      if (!en) begin
        pending  = 0;
        draining = 0;
      end else if (pending && edge_no == due) begin
        e_valid  = 1;
        e_fine   = pfine;
        e_coarse = pcoarse;
        e_sat    = (pfine == NTAP);
        pending  = 0;
        draining = 1;
      end else if (draining) begin
        if (!h2[0]) draining = 0;
      end else if (!pending && cap) begin
        pending = 1;
        due     = (edge_no - 2) + LATENCY;
        pfine   = ref_fine(h2);
        pcoarse = c2;
      end
      h3 = h2; h2 = h1; h1 = taps_drv;
      c2 = c1; c1 = mcnt;
      if (en) mcnt = mcnt + 8'd1;
    end
    e_busy = pending || draining;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      if (valid === 1'b1) n_valid++;
      chk("valid_o", 32'(valid), 32'(e_valid));
      chk("busy_o", 32'(busy), 32'(e_busy));
      chk("fine_o", 32'(fine), 32'(e_fine));
      chk("coarse_o", 32'(coarse), 32'(e_coarse));
      chk("sat_o", 32'(sat), 32'(e_sat));
    end
  end

  task automatic wait_cnt(input logic [7:0] v);
    int i;
    for (i = 0; i < 400; i++) begin
      if (mcnt == v) break;
      @(negedge clk);
    end
    if (i == 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cnt: counter never reached %0h", v);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int hold;
    int n;
    logic [15:0] t;

    set_taps(16'hFFFF);
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_fine", 32'(fine), 0);
    chk("rst_coarse", 32'(coarse), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_busy", 32'(busy), 0);
    set_taps(16'h0000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal hit captured at coarse 0x12
    wait_cnt(8'h12);
    set_taps(16'h003F);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("nom_valid", 32'(valid), 1);
    chk("nom_fine", 32'(fine), 6);
    chk("nom_coarse", 32'(coarse), 32'h12);
    chk("nom_sat", 32'(sat), 0);
    set_taps(16'h0000);
    repeat (6) @(negedge clk);

    // Saturated line
    set_taps(16'hFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sat_valid", 32'(valid), 1);
    chk("sat_fine", 32'(fine), 16);
    chk("sat_flag", 32'(sat), 1);
    set_taps(16'h0000);
    repeat (6) @(negedge clk);

    // Bubble in the thermometer code
    set_taps(16'h00F7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bubble_fine", 32'(fine), 32'(BUBBLE_EXP));
    set_taps(16'h0000);
    repeat (6) @(negedge clk);

    // Dead time: long pulse yields one result, short gap then a new hit
    v0 = n_valid;
    set_taps(16'h00FF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    set_taps(16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk("dead_one_result", 32'(n_valid - v0), 1);
    set_taps(16'h0003);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("dead_second_valid", 32'(valid), 1);
    chk("dead_second_fine", 32'(fine), 2);
    set_taps(16'h0000);
    repeat (6) @(negedge clk);

    // Capture at counter all-ones, then wrap
    wait_cnt(8'hFF);
    set_taps(16'h0001);
    @(posedge clk);
    @(negedge clk);
    chk("cnt_wrap", 32'(dut.coarse_cnt), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wrap_valid", 32'(valid), 1);
    chk("wrap_coarse", 32'(coarse), 32'hFF);
    set_taps(16'h0000);
    repeat (6) @(negedge clk);

    // Reset one cycle after the capture edge kills the result
    v0 = n_valid;
    set_taps(16'h000F);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    set_taps(16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_rst_no_valid", 32'(n_valid - v0), 0);

    // Enable dropped while converting cancels the result
    v0 = n_valid;
    set_taps(16'h0007);
    repeat (3) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    set_taps(16'h0000);
    repeat (8) @(negedge clk);
    chk("abort_en_no_valid", 32'(n_valid - v0), 0);
    chk("abort_en_idle", 32'(busy), 0);

    // Randomized traffic checked by the model
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 4))
        0:       t = 16'h0000;
        1:       t = 16'($urandom);
        default: begin
          n = $urandom_range(0, 16);
          t = (16'(1) << n) - 16'd1;
          if ($urandom_range(0, 3) == 0) t = t ^ (16'(1) << $urandom_range(0, 15));
        end
      endcase
      set_taps(t);
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) begin
        if ($urandom_range(0, 11) == 0) en = 1'b0;
        else                            en = 1'b1;
        if ($urandom_range(0, 59) == 0) rst_n = 1'b0;
        else                            rst_n = 1'b1;
        @(negedge clk);
      end
    end
    en    = 1'b1;
    rst_n = 1'b1;
    set_taps(16'h0000);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
